// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream types and helpers used by the stream blocks.
package axi4_stream_pkg;

  // Default field widths for the shared word type.
  localparam int AXIS_TDATA_W    = 32;
  localparam int AXIS_TUSER_W    = 1;
  localparam int AXIS_TDEST_W    = 1;
  localparam int AXIS_TID_W      = 1;
  localparam int AXIS_MAX_KEEP_W = 64;

  // One stream beat at the default widths.
  typedef struct packed {
    logic [AXIS_TDATA_W-1:0]   tdata;
    logic [AXIS_TDATA_W/8-1:0] tkeep;
    logic [AXIS_TDATA_W/8-1:0] tstrb;
    logic                      tlast;
    logic [AXIS_TUSER_W-1:0]   tuser;
    logic [AXIS_TDEST_W-1:0]   tdest;
    logic [AXIS_TID_W-1:0]     tid;
  } axi4_stream_word_t;

  // Framer control states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } framer_state_t;

  // Number of valid byte lanes in a tkeep vector (zero-extended to the max width).
  function automatic logic [6:0] popcount(input logic [AXIS_MAX_KEEP_W-1:0] keep);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < AXIS_MAX_KEEP_W; i++) begin
      if (keep[i]) cnt = cnt + 7'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TKEEP_WIDTH-1:0] tstrb;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TID_WIDTH-1:0]   tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_len_framer.sv
// Prepends a byte-length header word to each packet drained from the packet
// FIFO and flags packets whose payload byte count disagrees with that length.
module axi4_stream_len_framer
  import axi4_stream_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int TUSER_WIDTH    = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int PKT_SIZE_WIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PKT_SIZE_WIDTH:0] pkt_size_i,
  axi4_stream_if.slave            pkt_i,
  axi4_stream_if.master           pkt_o,
  output logic                    len_err_o,
  output logic [15:0]             pkts_sent_o
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int SIZE_W = PKT_SIZE_WIDTH + 1;
  localparam logic [SIZE_W-1:0] BEAT_BYTES = SIZE_W'(KEEP_W);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]      tkeep;
    logic [KEEP_W-1:0]      tstrb;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
  } word_t;

  framer_state_t     state_q, state_d;
  word_t             out_word_q, out_word_d;
  logic              out_valid_q, out_valid_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              len_err_q, len_err_d;
  logic [15:0]       pkts_sent_q, pkts_sent_d;

  word_t             in_word;
  word_t             hdr_word;
  logic [SIZE_W-1:0] last_bytes;
  logic [SIZE_W-1:0] total_bytes;
  logic              out_free;

  // The output register can take a new word when empty or draining this cycle.
  assign out_free     = !out_valid_q || pkt_o.tready;
  assign pkt_i.tready = (state_q == ST_PAYLOAD) && out_free;

  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = out_word_q.tdata;
  assign pkt_o.tkeep  = out_word_q.tkeep;
  assign pkt_o.tstrb  = out_word_q.tstrb;
  assign pkt_o.tlast  = out_word_q.tlast;
  assign pkt_o.tuser  = out_word_q.tuser;
  assign pkt_o.tdest  = out_word_q.tdest;
  assign pkt_o.tid    = out_word_q.tid;
  assign len_err_o    = len_err_q;
  assign pkts_sent_o  = pkts_sent_q;

  // Build the pass-through word and the length header from the current input beat.
  always_comb begin
    in_word.tdata  = pkt_i.tdata;
    in_word.tkeep  = pkt_i.tkeep;
    in_word.tstrb  = pkt_i.tstrb;
    in_word.tlast  = pkt_i.tlast;
    in_word.tuser  = pkt_i.tuser;
    in_word.tdest  = pkt_i.tdest;
    in_word.tid    = pkt_i.tid;
    hdr_word.tdata = TDATA_WIDTH'(pkt_size_i);
    hdr_word.tkeep = '1;
    hdr_word.tstrb = '1;
    hdr_word.tlast = 1'b0;
    hdr_word.tuser = pkt_i.tuser;
    hdr_word.tdest = pkt_i.tdest;
    hdr_word.tid   = pkt_i.tid;
    last_bytes     = SIZE_W'(popcount(AXIS_MAX_KEEP_W'(pkt_i.tkeep)));
    total_bytes    = byte_cnt_q + last_bytes;
  end

  // Next-state logic: header insertion in IDLE, payload forwarding and length check in PAYLOAD.
  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q && !pkt_o.tready;
    size_d      = size_q;
    byte_cnt_d  = byte_cnt_q;
    len_err_d   = 1'b0;
    pkts_sent_d = pkts_sent_q +
                  ((out_valid_q && pkt_o.tready && out_word_q.tlast) ? 16'd1 : 16'd0);
    case (state_q)
      ST_IDLE: begin
        if (pkt_i.tvalid && out_free) begin
          out_word_d  = hdr_word;
          out_valid_d = 1'b1;
          size_d      = pkt_size_i;
          byte_cnt_d  = '0;
          state_d     = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pkt_i.tvalid && out_free) begin
          out_word_d  = in_word;
          out_valid_d = 1'b1;
          if (pkt_i.tlast) begin
            byte_cnt_d = total_bytes;
            len_err_d  = (total_bytes != size_q);
            state_d    = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BEAT_BYTES;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears the output stage immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      size_q      <= '0;
      byte_cnt_q  <= '0;
      len_err_q   <= 1'b0;
      pkts_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      size_q      <= size_d;
      byte_cnt_q  <= byte_cnt_d;
      len_err_q   <= len_err_d;
      pkts_sent_q <= pkts_sent_d;
    end
  end

endmodule
